// File: rtl/mc_control_unit.sv
// Multi-cycle control unit: owns pc/ir and sequences FETCH/DECODE/EXEC/MEM/WB.
// Optional PERF_COUNT_EN adds cycle_cnt/retire_cnt output ports.
module mc_control_unit #(
  parameter int          XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC = 'h28,
  parameter int          MAX_RETIRE = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     ins,
  input  logic            zero,
  input  logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic [31:0]     ir,
  output logic            reg_write,
  output logic            alu_src,
  output logic            mem_read,
  output logic            mem_write,
  output logic [1:0]      wb_sel,
  output logic [2:0]      alu_op,
`ifdef PERF_COUNT_EN
  output logic [31:0]     cycle_cnt,
  output logic [31:0]     retire_cnt,
`endif
  output logic [2:0]      state,
  output logic            halted,
  output logic            illegal
);

  // state | meaning
  // FETCH  | latch ins into ir
  // DECODE | classify opcode, trap unknown ones
  // EXEC   | ALU op; branch/jal resolve pc here
  // MEM    | load/store strobe
  // WB     | register write, pc+4
  // HALT   | frozen until reset
  localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
                         S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd7;

  localparam logic [6:0] OP_R = 7'h33, OP_I = 7'h13, OP_LD = 7'h03,
                         OP_ST = 7'h23, OP_BR = 7'h63, OP_JAL = 7'h6F;

  logic [2:0] state_next;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       legal;
  logic       retire;
  logic       retire_hit;
  logic       br_taken;

  assign op       = ir[6:0];
  assign funct3   = ir[14:12];
  assign pc_plus4 = pc + XLEN'(4);
  assign halted   = (state == S_HALT);
  assign legal    = (op == OP_R) || (op == OP_I) || (op == OP_LD) ||
                    (op == OP_ST) || (op == OP_BR) || (op == OP_JAL);
  assign br_taken = ((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero);
  assign retire   = ((state == S_EXEC) && ((op == OP_BR) || (op == OP_JAL))) ||
                    ((state == S_MEM) && (op == OP_ST)) ||
                    (state == S_WB);

`ifdef PERF_COUNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_cnt  <= '0;
      retire_cnt <= '0;
    end else begin
      if (state != S_HALT) cycle_cnt <= cycle_cnt + 32'd1;
      if (retire) retire_cnt <= retire_cnt + 32'd1;
    end
  end
  assign retire_hit = (MAX_RETIRE != 0) && ((retire_cnt + 32'd1) == 32'(MAX_RETIRE));
`else
  generate
    if (MAX_RETIRE != 0) begin : g_retire
      localparam int RW = $clog2(MAX_RETIRE + 1);
      logic [RW-1:0] retire_q;
      always_ff @(posedge clk) begin
        if (!rst_n)      retire_q <= '0;
        else if (retire) retire_q <= retire_q + RW'(1);
      end
      assign retire_hit = (retire_q + RW'(1)) == RW'(MAX_RETIRE);
    end else begin : g_no_retire
      assign retire_hit = 1'b0;
    end
  endgenerate
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_FETCH;
      pc      <= RESET_PC;
      ir      <= '0;
      illegal <= 1'b0;
    end else begin
      state <= state_next;
      if (state == S_FETCH) ir <= ins;
      if ((state == S_DECODE) && !legal) illegal <= 1'b1;
      if (state == S_EXEC) begin
        if (op == OP_JAL)     pc <= pc + imm;
        else if (op == OP_BR) pc <= br_taken ? pc + imm : pc_plus4;
      end
      if (((state == S_MEM) && (op == OP_ST)) || (state == S_WB)) pc <= pc_plus4;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: state_next = legal ? S_EXEC : S_HALT;
      S_EXEC: begin
        if ((op == OP_BR) || (op == OP_JAL))  state_next = retire_hit ? S_HALT : S_FETCH;
        else if ((op == OP_LD) || (op == OP_ST)) state_next = S_MEM;
        else                                  state_next = S_WB;
      end
      S_MEM: begin
        if (op == OP_LD) state_next = S_WB;
        else             state_next = retire_hit ? S_HALT : S_FETCH;
      end
      S_WB:     state_next = retire_hit ? S_HALT : S_FETCH;
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_FETCH;
    endcase
  end

  // Strobes are forced low while reset is held so an aborted access never lands.
  always_comb begin
    reg_write = 1'b0;
    alu_src   = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    wb_sel    = 2'd0;
    alu_op    = 3'b010;
    case (state)
      S_EXEC: begin
        alu_src = (op == OP_I) || (op == OP_LD) || (op == OP_ST) || (op == OP_JAL);
        if ((op == OP_R) || (op == OP_I)) begin
          case (funct3)
            3'b000:  alu_op = ((op == OP_R) && ir[30]) ? 3'b110 : 3'b010;
            3'b111:  alu_op = 3'b000;
            3'b110:  alu_op = 3'b001;
            3'b010:  alu_op = 3'b111;
            default: alu_op = 3'b010;
          endcase
        end else if (op == OP_BR) begin
          alu_op = 3'b110;
        end
        if (op == OP_JAL) begin
          reg_write = rst_n;
          wb_sel    = 2'd2;
        end
      end
      S_MEM: begin
        mem_read  = rst_n && (op == OP_LD);
        mem_write = rst_n && (op == OP_ST);
      end
      S_WB: begin
        reg_write = rst_n;
        wb_sel    = (op == OP_LD) ? 2'd1 : 2'd0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: default instance plus a MAX_RETIRE=3 instance.
module tb_mc_control_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ins;
  logic        zero;
  logic [31:0] imm;

  logic [31:0] pc, pc_plus4, ir;
  logic        reg_write, alu_src, mem_read, mem_write, halted, illegal;
  logic [1:0]  wb_sel;
  logic [2:0]  alu_op, state;

  logic [31:0] pc2, pc_plus4_2, ir2;
  logic        reg_write2, alu_src2, mem_read2, mem_write2, halted2, illegal2;
  logic [1:0]  wb_sel2;
  logic [2:0]  alu_op2, state2;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] I_ADD = 32'h002081B3, I_SUB = 32'h402081B3,
                          I_AND = 32'h0020F1B3, I_LW  = 32'h00012083,
                          I_SW  = 32'h00112023, I_BEQ = 32'h00000063,
                          I_BNE = 32'h00001063, I_JAL = 32'h0000006F,
                          I_BAD = 32'h0000007F;

  always #5 clk = ~clk;

  mc_control_unit dut (
    .clk(clk), .rst_n(rst_n), .ins(ins), .zero(zero), .imm(imm),
    .pc(pc), .pc_plus4(pc_plus4), .ir(ir), .reg_write(reg_write),
    .alu_src(alu_src), .mem_read(mem_read), .mem_write(mem_write),
    .wb_sel(wb_sel), .alu_op(alu_op), .state(state), .halted(halted),
    .illegal(illegal)
  );

  mc_control_unit #(.MAX_RETIRE(3)) dut_lim (
    .clk(clk), .rst_n(rst_n), .ins(ins), .zero(zero), .imm(imm),
    .pc(pc2), .pc_plus4(pc_plus4_2), .ir(ir2), .reg_write(reg_write2),
    .alu_src(alu_src2), .mem_read(mem_read2), .mem_write(mem_write2),
    .wb_sel(wb_sel2), .alu_op(alu_op2), .state(state2), .halted(halted2),
    .illegal(illegal2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] pc_frozen;
    rst_n = 1'b0; ins = 32'h0; zero = 1'b0; imm = 32'h0;

    // Reset
    step(); step();
    chk("rst_pc", pc, 32'h28);
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_ir", ir, 32'h0);
    chk("rst_strobes", {29'd0, reg_write, mem_read, mem_write}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    rst_n = 1'b1;
    chk("fetch_strobes", {29'd0, reg_write, mem_read, mem_write}, 32'd0);

    // add
    ins = I_ADD;
    step(); chk("add_s1", {29'd0, state}, 32'd1); chk("add_ir", ir, I_ADD);
    step(); chk("add_s2", {29'd0, state}, 32'd2);
    chk("add_aluop", {29'd0, alu_op}, 32'b010);
    chk("add_alusrc", {31'd0, alu_src}, 32'd0);
    chk("add_rw_exec", {31'd0, reg_write}, 32'd0);
    step(); chk("add_s4", {29'd0, state}, 32'd4);
    chk("add_rw_wb", {31'd0, reg_write}, 32'd1);
    chk("add_wbsel", {30'd0, wb_sel}, 32'd0);
    step(); chk("add_s0", {29'd0, state}, 32'd0); chk("add_pc", pc, 32'h2C);

    // sub, and
    ins = I_SUB;
    step(); step(); chk("sub_aluop", {29'd0, alu_op}, 32'b110);
    step(); step(); chk("sub_pc", pc, 32'h30);
    ins = I_AND;
    step(); step(); chk("and_aluop", {29'd0, alu_op}, 32'b000);
    step(); step(); chk("and_pc", pc, 32'h34);

    // lw: 5 cycles
    ins = I_LW;
    step(); step();
    chk("lw_alusrc", {31'd0, alu_src}, 32'd1);
    chk("lw_mr_exec", {31'd0, mem_read}, 32'd0);
    step(); chk("lw_s3", {29'd0, state}, 32'd3);
    chk("lw_mr_mem", {31'd0, mem_read}, 32'd1);
    chk("lw_rw_mem", {31'd0, reg_write}, 32'd0);
    step(); chk("lw_s4", {29'd0, state}, 32'd4);
    chk("lw_rw_wb", {31'd0, reg_write}, 32'd1);
    chk("lw_wbsel", {30'd0, wb_sel}, 32'd1);
    chk("lw_mr_wb", {31'd0, mem_read}, 32'd0);
    step(); chk("lw_pc", pc, 32'h38); chk("lw_s0", {29'd0, state}, 32'd0);

    // sw: 4 cycles, never writes the register file
    ins = I_SW;
    step(); step(); chk("sw_rw_exec", {31'd0, reg_write}, 32'd0);
    step(); chk("sw_mw_mem", {31'd0, mem_write}, 32'd1);
    chk("sw_rw_mem", {31'd0, reg_write}, 32'd0);
    step(); chk("sw_pc", pc, 32'h3C); chk("sw_s0", {29'd0, state}, 32'd0);

    // beq taken
    do_reset();
    ins = I_BEQ; imm = 32'd16; zero = 1'b1;
    step(); step(); chk("beq_aluop", {29'd0, alu_op}, 32'b110);
    step(); chk("beq_t_pc", pc, 32'h38); chk("beq_s0", {29'd0, state}, 32'd0);
    // beq not taken
    do_reset();
    zero = 1'b0;
    step(); step(); step(); chk("beq_nt_pc", pc, 32'h2C);
    // bne taken
    do_reset();
    ins = I_BNE;
    step(); step(); step(); chk("bne_t_pc", pc, 32'h38);
    // bne not taken
    zero = 1'b1;
    step(); step(); step(); chk("bne_nt_pc", pc, 32'h3C);
    // beq +4 to reach 0x40
    ins = I_BEQ; imm = 32'd4;
    step(); step(); step(); chk("beq_to40", pc, 32'h40);

    // jal imm=-8
    ins = I_JAL; imm = 32'hFFFF_FFF8;
    step(); step(); chk("jal_s2", {29'd0, state}, 32'd2);
    chk("jal_rw", {31'd0, reg_write}, 32'd1);
    chk("jal_wbsel", {30'd0, wb_sel}, 32'd2);
    chk("jal_aluop", {29'd0, alu_op}, 32'b010);
    chk("jal_pc4", pc_plus4, 32'h44);
    step(); chk("jal_pc", pc, 32'h38); chk("jal_s0", {29'd0, state}, 32'd0);

    // illegal opcode -> HALT, pc frozen
    ins = I_BAD;
    pc_frozen = 32'h38;
    step(); chk("bad_s1", {29'd0, state}, 32'd1);
    step(); chk("bad_halt", {29'd0, state}, 32'd7);
    chk("bad_halted", {31'd0, halted}, 32'd1);
    chk("bad_illegal", {31'd0, illegal}, 32'd1);
    ins = I_ADD;
    for (int i = 0; i < 10; i++) step();
    chk("halt_pc", pc, pc_frozen);
    chk("halt_state", {29'd0, state}, 32'd7);
    chk("halt_strobes", {29'd0, reg_write, mem_read, mem_write}, 32'd0);

    // reset during MEM of a store aborts it
    do_reset();
    chk("rst_clr_illegal", {31'd0, illegal}, 32'd0);
    ins = I_SW;
    step(); step(); step();
    chk("abort_mem_s3", {29'd0, state}, 32'd3);
    chk("abort_mw_pre", {31'd0, mem_write}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_mw_low", {31'd0, mem_write}, 32'd0);
    step();
    chk("abort_pc", pc, 32'h28);
    chk("abort_state", {29'd0, state}, 32'd0);
    rst_n = 1'b1;

    // MAX_RETIRE=3
    do_reset();
    ins = I_ADD;
    for (int i = 0; i < 8; i++) step();
    chk("lim_not_halted", {31'd0, halted2}, 32'd0);
    chk("lim_pc2", pc2, 32'h30);
    for (int i = 0; i < 4; i++) step();
    chk("lim_halted", {31'd0, halted2}, 32'd1);
    chk("lim_illegal", {31'd0, illegal2}, 32'd0);
    chk("lim_pc_final", pc2, 32'h34);
    chk("unlim_running", {29'd0, state}, 32'd0);
    step(); step();
    chk("lim_stays", {29'd0, state2}, 32'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
